// File: rtl/mac_psum_acc.sv
// ---------------------------------------------------------------------------
// mac_psum_acc
//
// Partial-sum accumulator and requantizer on the output side of the per-lane
// MAC array. Sums one signed dot product per beat over a configured number of
// input-channel groups, adds a bias, then round-shifts and saturates the sum
// into an activation word. The result is handed over a valid/ready port.
//
// Build option:
//   MAC_PSUM_RELU_EN  when defined, negative results are clamped to 0 (ReLU).
//                     Latency and handshakes are identical in both builds.
//
// Ports:
//   clk         clock, all logic on the rising edge
//   rst         synchronous active-high reset, aborts any run
//   start       one-cycle pulse, latches cfg_* (accepted only when idle)
//   cfg_groups  dot products per output (0 treated as 1)
//   cfg_pixels  outputs per run (0 treated as 1)
//   cfg_shift   rounding right-shift amount, 0..31
//   cfg_bias    signed bias added once per output
//   i_vld       dot product valid
//   i_rdy       block accepts a dot product (accumulating)
//   i_dat       signed dot product
//   o_vld       activation valid
//   o_rdy       downstream accepts the activation
//   o_dat       signed activation
//   busy        high whenever a run is in progress
//   done        one-cycle pulse after the last activation is accepted
// ---------------------------------------------------------------------------

`ifndef MAX_DW
`define MAX_DW 8
`endif
`ifndef MAX_DW2
`define MAX_DW2 16
`endif
`ifndef log2_Tin
`define log2_Tin 4
`endif

module mac_psum_acc #(
    parameter int unsigned IN_W  = `MAX_DW2 + `log2_Tin,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned OUT_W = `MAX_DW,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        cfg_groups,
    input  logic [CNT_W-1:0]        cfg_pixels,
    input  logic [4:0]              cfg_shift,
    input  logic [ACC_W-1:0]        cfg_bias,
    input  logic                    i_vld,
    output logic                    i_rdy,
    input  logic [IN_W-1:0]         i_dat,
    output logic                    o_vld,
    input  logic                    o_rdy,
    output logic signed [OUT_W-1:0] o_dat,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_QUANT,
        S_OUT
    } state_t;

    state_t state;
    state_t state_nxt;

    // Latched configuration
    logic [CNT_W-1:0]        groups_q;
    logic [CNT_W-1:0]        pixels_q;
    logic [4:0]              shift_q;
    logic signed [ACC_W-1:0] bias_q;

    // Run state
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        grp_cnt;
    logic [CNT_W-1:0]        pix_cnt;

    // Handshake qualifiers
    logic beat;
    logic last_beat;
    logic out_hs;
    logic last_pix;

    // Requantizer
    logic signed [ACC_W-1:0] dat_ext;
    logic signed [ACC_W:0]   acc_ext;
    logic signed [ACC_W:0]   rnd_inc;
    logic signed [ACC_W:0]   rnd_sum;
    logic signed [ACC_W:0]   shifted;
    logic signed [OUT_W-1:0] sat_res;
    logic signed [OUT_W-1:0] quant_res;

    // Saturation bounds expressed at the widened rounding width
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN =
        {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    // Zero in either count field means "one"
    logic [CNT_W-1:0] groups_eff;
    logic [CNT_W-1:0] pixels_eff;

    assign groups_eff = (cfg_groups == '0) ? CNT_W'(1) : cfg_groups;
    assign pixels_eff = (cfg_pixels == '0) ? CNT_W'(1) : cfg_pixels;

    assign dat_ext   = ACC_W'($signed(i_dat));
    assign beat      = (state == S_ACC) && i_vld;
    assign last_beat = beat && (grp_cnt == groups_q - CNT_W'(1));
    assign out_hs    = (state == S_OUT) && o_rdy;
    assign last_pix  = (pix_cnt == pixels_q - CNT_W'(1));

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ACC;
            S_ACC:   if (last_beat) state_nxt = S_QUANT;
            S_QUANT: state_nxt = S_OUT;
            S_OUT:   if (o_rdy) state_nxt = last_pix ? S_IDLE : S_ACC;
            default: state_nxt = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: state-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        i_rdy = 1'b0;
        o_vld = 1'b0;
        busy  = 1'b1;
        case (state)
            S_IDLE:  busy  = 1'b0;
            S_ACC:   i_rdy = 1'b1;
            S_QUANT: ;
            S_OUT:   o_vld = 1'b1;
            default: busy  = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Requantizer: round-half-up arithmetic shift, saturate, optional ReLU.
    // The rounding add runs one bit wider than the accumulator so that adding
    // 2^(s-1) to a near-maximum sum cannot wrap.
    // -----------------------------------------------------------------------
    always_comb begin
        acc_ext = {acc[ACC_W-1], acc};
        rnd_inc = '0;
        if (shift_q != 5'd0) begin
            rnd_inc = (ACC_W+1)'(1) << (shift_q - 5'd1);
        end
        rnd_sum = acc_ext + rnd_inc;
        shifted = rnd_sum >>> shift_q;

        if (shifted > SAT_MAX) begin
            sat_res = SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_res = SAT_MIN[OUT_W-1:0];
        end else begin
            sat_res = shifted[OUT_W-1:0];
        end

`ifdef MAC_PSUM_RELU_EN
        quant_res = sat_res[OUT_W-1] ? '0 : sat_res;
`else
        quant_res = sat_res;
`endif
    end

    // -----------------------------------------------------------------------
    // Datapath: config latch, accumulator, counters, output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            groups_q <= '0;
            pixels_q <= '0;
            shift_q  <= '0;
            bias_q   <= '0;
            acc      <= '0;
            grp_cnt  <= '0;
            pix_cnt  <= '0;
            o_dat    <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        groups_q <= groups_eff;
                        pixels_q <= pixels_eff;
                        shift_q  <= cfg_shift;
                        bias_q   <= cfg_bias;
                        acc      <= cfg_bias;
                        grp_cnt  <= '0;
                        pix_cnt  <= '0;
                    end
                end
                S_ACC: begin
                    if (beat) begin
                        acc     <= acc + dat_ext;
                        grp_cnt <= grp_cnt + CNT_W'(1);
                    end
                end
                S_QUANT: begin
                    o_dat <= quant_res;
                end
                S_OUT: begin
                    if (out_hs) begin
                        pix_cnt <= pix_cnt + CNT_W'(1);
                        if (last_pix) begin
                            done <= 1'b1;
                        end else begin
                            acc     <= bias_q;
                            grp_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_psum_acc.sv
// ---------------------------------------------------------------------------
// tb_mac_psum_acc
//
// Self-checking bench for mac_psum_acc: directed scenarios followed by
// randomized runs, each result compared against a behavioural model.
// ---------------------------------------------------------------------------
module tb_mac_psum_acc;

    localparam int IN_W  = 20;
    localparam int ACC_W = 32;
    localparam int OUT_W = 8;
    localparam int CNT_W = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [CNT_W-1:0]        cfg_groups;
    logic [CNT_W-1:0]        cfg_pixels;
    logic [4:0]              cfg_shift;
    logic [ACC_W-1:0]        cfg_bias;
    logic                    i_vld;
    logic                    i_rdy;
    logic [IN_W-1:0]         i_dat;
    logic                    o_vld;
    logic                    o_rdy;
    logic signed [OUT_W-1:0] o_dat;
    logic                    busy;
    logic                    done;

    int n_checks = 0;
    int n_fail   = 0;
    int dq[$];

    mac_psum_acc #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_groups (cfg_groups),
        .cfg_pixels (cfg_pixels),
        .cfg_shift  (cfg_shift),
        .cfg_bias   (cfg_bias),
        .i_vld      (i_vld),
        .i_rdy      (i_rdy),
        .i_dat      (i_dat),
        .o_vld      (o_vld),
        .o_rdy      (o_rdy),
        .o_dat      (o_dat),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: bias + sum wrapped to 32 bits, round-half-up divide by 2^s
    // (floor semantics), clamp to the 8-bit signed range.
    function automatic longint model_out(input longint bias, input longint sum, input int s);
        longint a, num, d, q;
        a = longint'(int'(bias + sum));
        if (s == 0) begin
            q = a;
        end else begin
            num = a + (longint'(1) << (s - 1));
            d   = longint'(1) << s;
            q   = num / d;
            if ((num % d) != 0 && num < 0) q = q - 1;
        end
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
`ifdef MAC_PSUM_RELU_EN
        if (q < 0) q = 0;
`endif
        return q;
    endfunction

    function automatic int rand_dat();
        int m;
        m = 1 << $urandom_range(1, 18);
        return int'($urandom_range(0, 2 * m)) - m;
    endfunction

    task automatic do_reset();
        rst        = 1'b1;
        start      = 1'b0;
        i_vld      = 1'b0;
        i_dat      = '0;
        o_rdy      = 1'b0;
        cfg_groups = '0;
        cfg_pixels = '0;
        cfg_shift  = '0;
        cfg_bias   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one job; called and returns at a falling edge. When directed is
    // set, beats come back to back from dq; otherwise random data with gaps.
    // hold < 0 picks a random o_rdy hold per output.
    task automatic run_job(input int groups, input int pixels, input int shift,
                           input int bias, input bit directed, input int hold);
        int     ng, np, acc_n, h, cnt, d;
        longint sum, exp;
        bit     vld;
        ng = (groups == 0) ? 1 : groups;
        np = (pixels == 0) ? 1 : pixels;
        if (n_fail != 0) do_reset();

        start      = 1'b1;
        cfg_groups = CNT_W'(groups);
        cfg_pixels = CNT_W'(pixels);
        cfg_shift  = 5'(shift);
        cfg_bias   = ACC_W'(bias);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);

        for (int p = 0; p < np; p++) begin
            check("i_rdy_acc", i_rdy, 1);
            sum   = 0;
            acc_n = 0;
            while (acc_n < ng) begin
                if (directed) begin
                    vld = 1'b1;
                    d   = dq.pop_front();
                end else begin
                    vld = ($urandom_range(0, 3) != 0);
                    d   = rand_dat();
                end
                i_vld = vld;
                i_dat = IN_W'(d);
                if (vld) begin
                    sum += d;
                    acc_n++;
                end
                @(negedge clk);
            end
            i_vld = 1'b0;
            exp   = model_out(bias, sum, shift);

            check("o_vld_in_quant", o_vld, 0);
            cnt = 0;
            while (!o_vld && cnt < 8) begin
                @(negedge clk);
                cnt++;
            end
            check("quant_latency", cnt, 1);

            h = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
            repeat (h) begin
                check("hold_o_vld", o_vld, 1);
                check("hold_o_dat", o_dat, exp);
                check("hold_i_rdy", i_rdy, 0);
                // Junk that must be ignored while an output is pending
                i_vld      = 1'($urandom_range(0, 1));
                i_dat      = IN_W'($urandom);
                start      = 1'($urandom_range(0, 1));
                cfg_groups = CNT_W'($urandom_range(0, 9));
                cfg_pixels = CNT_W'($urandom_range(0, 9));
                cfg_shift  = 5'($urandom);
                cfg_bias   = ACC_W'($urandom);
                @(negedge clk);
            end
            i_vld = 1'b0;
            start = 1'b0;
            o_rdy = 1'b1;
            check("o_vld", o_vld, 1);
            check("o_dat", o_dat, exp);
            @(negedge clk);
            o_rdy = 1'b0;
            if (p == np - 1) begin
                check("done", done, 1);
                check("busy_end", busy, 0);
                @(negedge clk);
                check("done_one_cycle", done, 0);
            end else begin
                check("i_rdy_next_pixel", i_rdy, 1);
                check("done_early", done, 0);
            end
        end
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        check("rst_i_rdy", i_rdy, 0);
        check("rst_o_vld", o_vld, 0);
        check("rst_o_dat", o_dat, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // Basic sum of four beats
        dq = '{1, 2, 3, 4};
        run_job(4, 1, 0, 0, 1'b1, 0);

        // Rounding, positive and negative
        dq = '{6};
        run_job(1, 1, 2, 0, 1'b1, 0);
        dq = '{-6};
        run_job(1, 1, 2, 0, 1'b1, 0);

        // Saturation high and low
        dq = '{100, 100};
        run_job(2, 1, 0, 100, 1'b1, 0);
        dq = '{100, 100};
        run_job(2, 1, 0, -1000, 1'b1, 0);

        // Backpressure over two pixels
        dq = '{10, 20, 30, -5};
        run_job(2, 2, 1, 3, 1'b1, 5);

        // Zero groups and pixels behave as one
        dq = '{7};
        run_job(0, 0, 0, 0, 1'b1, 0);

        // Reset after two of four beats
        start      = 1'b1;
        cfg_groups = CNT_W'(4);
        cfg_pixels = CNT_W'(1);
        cfg_shift  = 5'd0;
        cfg_bias   = ACC_W'(50);
        @(negedge clk);
        start = 1'b0;
        i_vld = 1'b1;
        i_dat = IN_W'(1000);
        @(negedge clk);
        i_dat = IN_W'(2000);
        @(negedge clk);
        rst   = 1'b1;
        i_dat = IN_W'(3000);
        @(negedge clk);
        rst   = 1'b0;
        i_vld = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_i_rdy", i_rdy, 0);
        check("abort_o_vld", o_vld, 0);
        check("abort_o_dat", o_dat, 0);
        check("abort_done", done, 0);
        dq = '{1, 2, 3, 4};
        run_job(4, 1, 0, 0, 1'b1, 0);

        // Randomized jobs
        for (int j = 0; j < 40; j++) begin
            run_job(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 12)),
                    int'($urandom_range(0, 20000)) - 10000, 1'b0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_psum_acc.md
# mac_psum_acc

Partial-sum accumulator and requantizer on the output side of the per-lane MAC array. Consumes one signed Tin-lane dot product per cycle, sums it over a configured number of input-channel groups, adds a bias, then round-shifts and saturates the sum to an activation word. The activation word is presented on a valid/ready port to the output writer. `i_rdy` lets the upstream feed sequencer stall the MAC pipeline while a result is pending.

## Interface
- `IN_W`, default `` `MAX_DW2+`log2_Tin ``: width of the signed dot product from the MAC array.
- `ACC_W`, default 32: width of the signed accumulator and of the bias.
- `OUT_W`, default `` `MAX_DW ``: width of the signed output activation.
- `CNT_W`, default 16: width of the group and pixel counters.

Ports:
- `clk` input 1: the single clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle pulse that latches all `cfg_*` inputs; accepted only in IDLE.
- `cfg_groups` input CNT_W: number of dot products per output; 0 is treated as 1.
- `cfg_pixels` input CNT_W: number of outputs per run; 0 is treated as 1.
- `cfg_shift` input 5: right-shift amount, 0 to 31.
- `cfg_bias` input ACC_W: signed bias added once per output.
- `i_vld` input 1: dot-product valid.
- `i_rdy` output 1: block can accept a dot product.
- `i_dat` input IN_W: signed dot product.
- `o_vld` output 1: activation valid.
- `o_rdy` input 1: downstream accepts the activation.
- `o_dat` output OUT_W: signed activation.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse after the last activation is accepted.

## Operation
- The FSM has four states: IDLE, ACC, QUANT and OUT.
- IDLE:
  - `start` latches the config, clears the group counter and pixel counter, and loads the accumulator with `cfg_bias`.
  - The next state is ACC.
- ACC:
  - `i_rdy` is 1.
  - Each beat where `i_vld & i_rdy` adds the sign-extended `i_dat` to the accumulator and increments the group counter.
  - The beat that completes `cfg_groups` beats moves the FSM to QUANT.
- QUANT (one cycle), with s = `cfg_shift`:
  - If s > 0, compute r = (acc + 2^(s-1)) >>> s as an arithmetic shift. If s = 0, r = acc.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and register the result into `o_dat`.
  - Set `o_vld`. The next state is OUT.
- OUT:
  - `o_vld` and `o_dat` stay stable until `o_rdy`.
  - On `o_vld & o_rdy`, the pixel counter increments.
  - If that was the last pixel: go to IDLE, pulse `done`, and drop `o_vld`.
  - Otherwise: reload the accumulator with `cfg_bias`, clear the group counter, and go to ACC.
- Arithmetic:
  - The accumulator wraps in two's complement. Callers size ACC_W to hold `cfg_groups` × max |i_dat| + |bias|.
  - The rounding add is computed at ACC_W+1 bits, so it does not overflow.
- Boundary conditions:
  - `i_vld` while `i_rdy`=0 (IDLE, QUANT, OUT) is ignored: no accumulate and no count. The upstream must hold its data.
  - `start` outside IDLE is ignored.
  - `rst` at any point aborts the run: the FSM returns to IDLE and all outputs take their reset values.

## Timing
- Reset values: `i_rdy`=0, `o_vld`=0, `o_dat`=0, `busy`=0, `done`=0. The accumulator and both counters reset to 0.
- `start` in cycle t puts the FSM in ACC at t+1, with `i_rdy`=1 at t+1.
- The last group beat accepted in cycle t puts the FSM in QUANT at t+1, with `o_vld`=1 and `o_dat` valid at t+2.
- `o_rdy`=1 in cycle u:
  - If more pixels remain, `i_rdy`=1 again at u+1. The per-output overhead is therefore 2 cycles.
  - If this was the last pixel, `done`=1 at u+1.
- Back-to-back beats in ACC are accepted every cycle; there are no bubbles.

## Configuration
- Macro `` `MAC_PSUM_RELU_EN `` controls a ReLU stage.
  - Defined: in QUANT, any negative saturated result is replaced by 0, so `o_dat` ≥ 0 always.
  - Undefined: `o_dat` spans the full signed saturated range.
- Latency and handshakes are identical in both builds.

## Test plan
- Basic run: groups=4, pixels=1, shift=0, bias=0, `i_dat` = 1, 2, 3, 4 on consecutive cycles, `o_rdy`=1 → `o_dat`=10 at start+6; `done` pulses one cycle later.
- Rounding: groups=1, shift=2, bias=0, `i_dat`=6 → `o_dat`=2; then `i_dat`=-6 → -1 (floor of -4/4).
- Saturation (OUT_W=8): groups=2, bias=100, `i_dat` = 100, 100 → `o_dat`=127; with bias=-1000 → -128, or 0 when `MAC_PSUM_RELU_EN` is defined.
- Backpressure: pixels=2, groups=2, hold `o_rdy`=0 for 5 cycles → `o_dat` stays stable, `i_rdy`=0, and `i_vld` pulses during the hold do not change the second result.
- Zero config: groups=0, pixels=0, `i_dat`=7 → exactly one output, 7, then `done`.
- Reset mid-run: assert `rst` during ACC after 2 of 4 beats → next cycle `busy`=0 and `i_rdy`=0; a fresh run gives results unaffected by the aborted partial sum.
